mochila_obi_rr_arbiter: RTL
===========================

Name: mochila_obi_rr_arbiter

Overview:
- Shares the single mochila external-master OBI port between NMASTER requesters: ext core instr, ext core data, ext debug master, and ext peripheral slave.
- Replaces the plain N-to-1 crossbar on that path with a fair round-robin arbiter.
- Locks the slave address phase until grant and tracks in-order outstanding transactions, so each rvalid returns to the master that issued the request.

Parameters:
- NMASTER, 4, number of OBI requesters; legal range 2..8.
- MAX_OUTSTANDING, 2, depth of the route FIFO, i.e. the maximum number of granted transactions still awaiting rvalid; minimum 1.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of outstanding_o (derived; not to be overridden).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- master_req_i  input  obi_req_t[NMASTER]  requester address phases.
- master_resp_o  output  obi_resp_t[NMASTER]  per-requester gnt, rvalid and rdata.
- slave_req_o  output  obi_req_t  request forwarded to the shared port.
- slave_resp_i  input  obi_resp_t  response from the shared port.
- outstanding_o  output  CNT_W  number of granted transactions not yet answered.
- busy_o  output  1  high while outstanding_o != 0 or a lock is active.
- err_o  output  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
Reset:
- All state clears asynchronously on rst_i=1: rr_ptr=0, lock_valid=0, lock_idx=0, FIFO empty, err_o=0.
- slave_req_o is all-zero.
- master_resp_o has gnt=0 and rvalid=0 for every master.

Arbitration (combinational, zero added latency):
- If lock_valid=1, the selected master is lock_idx.
- Otherwise the selected master is the first i with master_req_i[i].req=1, scanning rr_ptr, rr_ptr+1, … modulo NMASTER.
- If no master is requesting, slave_req_o.req=0 and the remaining slave_req_o fields are 0.

Forwarding:
- If FIFO full, slave_req_o.req=0.
- Otherwise slave_req_o equals master_req_i[sel].
- master_resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req. All other gnts are 0.
- A full FIFO blocks a new request even if rvalid pops in the same cycle. There is no rvalid→req combinational path.

Handshake (slave_req_o.req & slave_resp_i.gnt):
- Push sel into the FIFO.
- rr_ptr <= (sel+1) mod NMASTER.
- lock_valid <= 0.

Lock:
- slave_req_o.req=1 without gnt sets lock_valid<=1 and lock_idx<=sel. This keeps the address phase stable at the slave as OBI requires.
- A locked master that drops req before gnt is an OBI violation: lock_valid<=0, err_o<=1, rr_ptr unchanged.

Response routing:
- rdata is broadcast to every master_resp_o[i].rdata.
- rvalid goes only to master_resp_o[fifo_head].rvalid, and the FIFO pops.
- rvalid while the FIFO is empty is dropped (no master sees it) and sets err_o<=1.

Simultaneous events and counters:
- Push and pop in the same cycle with 0 < count < MAX_OUTSTANDING: count is unchanged and the pointers advance.
- The response routed in that cycle belongs to the previous head.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o equals the FIFO count and is registered.
- busy_o = (outstanding_o != 0) | lock_valid.

Reset mid-operation:
- Outstanding routing is discarded.
- rvalids arriving after reset hit an empty FIFO and set err_o.

Test Plan:
- After reset, assert req on masters 0, 2 and 3 continuously with the slave granting every cycle → grants in order 0,2,3,0,2,…; with MAX_OUTSTANDING=2 and no rvalid, the third request stalls with slave_req_o.req=0 and outstanding_o=2.
- Master 1 requests addr=0x2000_0010 and the slave holds gnt=0 for 3 cycles while master 0 also requests → slave_req_o.addr stays 0x2000_0010 for all 3 cycles, busy_o=1, and master 1 is granted on cycle 4.
- Masters 0 and 3 are granted back-to-back; the slave returns rvalid with rdata 0xAAAA_0000 then 0xBBBB_0003 → only master 0 sees the first rvalid, only master 3 sees the second, and outstanding_o goes 2→1→0.
- FIFO holds 1 entry; a new grant and an rvalid occur in the same cycle → outstanding_o stays 1 and the rvalid is routed to the old head.
- rvalid with the FIFO empty, or the locked master dropping req before gnt → err_o=1 and remains 1 until rst_i.
- Assert rst_i for 1 cycle with 2 transactions outstanding → outstanding_o=0, busy_o=0, rr_ptr=0; the next simultaneous requests from masters 1 and 2 grant master 1 first.

Source files
------------

// File: rtl/mochila_obi_rr_arbiter_if.sv
// OBI bundle around the round-robin arbiter: NMASTER requester ports on one
// side and the single shared port on the other. Request fields are flattened
// per requester (req/we/be/addr/wdata) with the matching response (gnt/rvalid/rdata).
interface mochila_obi_rr_arbiter_if #(
  parameter int NMASTER = 4
);
  // Requester side
  logic [NMASTER-1:0] master_req;
  logic [NMASTER-1:0] master_we;
  logic [3:0]         master_be    [NMASTER];
  logic [31:0]        master_addr  [NMASTER];
  logic [31:0]        master_wdata [NMASTER];
  logic [NMASTER-1:0] master_gnt;
  logic [NMASTER-1:0] master_rvalid;
  logic [31:0]        master_rdata [NMASTER];

  // Shared port side
  logic               slave_req;
  logic               slave_we;
  logic [3:0]         slave_be;
  logic [31:0]        slave_addr;
  logic [31:0]        slave_wdata;
  logic               slave_gnt;
  logic               slave_rvalid;
  logic [31:0]        slave_rdata;

  // The arbiter itself: a slave to the requesters, a master to the shared port.
  modport slave (
    input  master_req, master_we, master_be, master_addr, master_wdata,
    output master_gnt, master_rvalid, master_rdata,
    output slave_req, slave_we, slave_be, slave_addr, slave_wdata,
    input  slave_gnt, slave_rvalid, slave_rdata
  );

  // The surrounding system: drives requests and the shared-port responses.
  modport master (
    output master_req, master_we, master_be, master_addr, master_wdata,
    input  master_gnt, master_rvalid, master_rdata,
    input  slave_req, slave_we, slave_be, slave_addr, slave_wdata,
    output slave_gnt, slave_rvalid, slave_rdata
  );
endinterface

// File: rtl/mochila_obi_rr_arbiter.sv
// Fair round-robin arbiter sharing one OBI port among NMASTER requesters.
// The address phase is locked to the selected master until granted, and a
// small in-order route FIFO steers each rvalid back to its issuing master.
module mochila_obi_rr_arbiter #(
  parameter  int NMASTER         = 4,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mochila_obi_rr_arbiter_if.slave bus_io,
  output logic [CNT_W-1:0]     outstanding_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int IDX_W = $clog2(NMASTER);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // State
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_idx_q,  lock_idx_d;
  logic             err_q,       err_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [IDX_W-1:0] route_q [MAX_OUTSTANDING];

  // Datapath / control
  logic [IDX_W-1:0]   sel;
  logic               sel_valid;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fwd_req;
  logic               push;
  logic               pop;
  logic [IDX_W-1:0]   head;
  logic [NMASTER-1:0] gnt_vec;
  logic [NMASTER-1:0] rvalid_vec;
  int                 cand;

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = route_q[rd_ptr_q];

  // Reset also forces the forwarded request low so nothing leaks out while held.
  assign fwd_req = sel_valid & ~fifo_full & ~rst_i;
  assign push    = fwd_req & bus_io.slave_gnt;
  assign pop     = bus_io.slave_rvalid & ~fifo_empty & ~rst_i;

  // Selection: a held lock wins, otherwise the first requester from rr_ptr onward.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = 0;
    if (lock_valid_q) begin
      sel       = lock_idx_q;
      sel_valid = bus_io.master_req[lock_idx_q];
    end else begin
      for (int k = 0; k < NMASTER; k++) begin
        cand = (int'(rr_ptr_q) + k) % NMASTER;
        if (!sel_valid && bus_io.master_req[cand]) begin
          sel       = IDX_W'(cand);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // Forward the selected address phase; every field is zero when nothing goes out.
  always_comb begin
    bus_io.slave_req   = 1'b0;
    bus_io.slave_we    = 1'b0;
    bus_io.slave_be    = '0;
    bus_io.slave_addr  = '0;
    bus_io.slave_wdata = '0;
    if (fwd_req) begin
      bus_io.slave_req   = 1'b1;
      bus_io.slave_we    = bus_io.master_we[sel];
      bus_io.slave_be    = bus_io.master_be[sel];
      bus_io.slave_addr  = bus_io.master_addr[sel];
      bus_io.slave_wdata = bus_io.master_wdata[sel];
    end
  end

  // Per-requester responses: gnt to the selected master, rvalid to the FIFO head, rdata broadcast.
  for (genvar gi = 0; gi < NMASTER; gi++) begin : g_resp
    assign gnt_vec[gi]             = push & (sel == IDX_W'(gi));
    assign rvalid_vec[gi]          = pop & (head == IDX_W'(gi));
    assign bus_io.master_rdata[gi] = bus_io.slave_rdata;
  end

  assign bus_io.master_gnt    = gnt_vec;
  assign bus_io.master_rvalid = rvalid_vec;

  // Next state: rotate/unlock on handshake, lock on a stalled request, flag OBI violations.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    err_d        = err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (push) begin
      rr_ptr_d     = (sel == IDX_W'(NMASTER - 1)) ? '0 : sel + IDX_W'(1);
      lock_valid_d = 1'b0;
    end else if (fwd_req) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = sel;
    end else if (lock_valid_q && !bus_io.master_req[lock_idx_q]) begin
      // Locked master withdrew its request before being granted.
      lock_valid_d = 1'b0;
      err_d        = 1'b1;
    end

    // A response with nobody waiting for it is dropped and flagged.
    if (bus_io.slave_rvalid && fifo_empty) begin
      err_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Route FIFO storage; entries are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      route_q[wr_ptr_q] <= sel;
    end
  end

  assign outstanding_o = count_q;
  assign busy_o        = (count_q != '0) | lock_valid_q;
  assign err_o         = err_q;

endmodule
